fetch_prefetch_unit: RTL
========================

Name: fetch_prefetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of the IF/ID pipe register.
- Generates fetch PCs and issues reads to a synchronous instruction ROM with 1-cycle read latency.
- Buffers fetched {PC+4, instruction} pairs in a small prefetch FIFO, so downstream stalls do not drop instructions.
- Accepts branch/jump/JR redirects resolved in MEM and squashes all wrong-path fetches.

Parameters:
- FIFO_DEPTH, 4, number of prefetch entries; power of two, minimum 2.
- RESET_PC, 32'h0040_0000, first fetch address after reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- imem_req  output  1  read strobe to instruction ROM.
- imem_addr  output  32  byte address of the read; bits [1:0] always 0.
- imem_rdata  input  32  instruction, valid the cycle after imem_req.
- redirect_valid  input  1  taken branch/jump/JR from MEM.
- redirect_pc  input  32  target address; bits [1:0] ignored and treated as 0.
- if_valid  output  1  FIFO head is valid.
- if_ready  input  1  IF/ID pipe accepts the head this cycle.
- if_instr  output  32  head instruction.
- if_pc4  output  32  head PC+4.

Behaviour:
- Reset (reset==0 at a clk edge):
  - fetch_pc <= RESET_PC; FIFO emptied; outstanding flag cleared; FSM -> S_BOOT.
  - Outputs: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc4=0.
  - Reset asserted mid-operation discards everything, including any in-flight ROM read.
- FSM states:
  - S_BOOT: no request; -> S_RUN next cycle.
  - S_RUN: normal fetch; redirect_valid -> S_FLUSH.
  - S_FLUSH: one bubble cycle, no request; -> S_RUN; a new redirect in S_FLUSH stays in S_FLUSH.
- Request rule (S_RUN only):
  - imem_req = (count + outstanding < FIFO_DEPTH) && !redirect_valid.
  - imem_addr = fetch_pc.
  - On request: fetch_pc <= fetch_pc + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0); outstanding <= 1; captured pc4 = fetch_pc + 4.
- Response: the cycle after a request, {pc4, imem_rdata} is pushed into the FIFO unless squashed. Because of credit counting, a push never sees a full FIFO.
- Pop: when if_valid && if_ready. Push and pop in the same cycle leave count unchanged. if_ready with an empty FIFO is a no-op.
- Latency: an instruction requested in cycle N is visible on if_* in cycle N+2 (registered FIFO head). Back-to-back throughput is 1 instruction per cycle with if_ready held high.
- Redirect (highest priority, over push, pop and request):
  - FIFO flushed; count <= 0.
  - The in-flight response of this cycle and the next is squashed.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - if_valid = 0 from the next cycle.
  - The first request to the target is issued 2 cycles after redirect_valid (after S_FLUSH). The target instruction appears on if_* 4 cycles after redirect_valid.
- if_instr and if_pc4 hold their last value when if_valid=0. After a flush they are 0 when empty.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds output perf_fetched[31:0], counting pops (if_valid && if_ready).
  - Adds output perf_redirects[31:0], counting redirect_valid cycles.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and counters are absent; no other behaviour changes.

Decomposition:
- fetch_pkg holds:
  - RESET_PC default constant.
  - fetch_state_t enum {S_BOOT, S_RUN, S_FLUSH}.
  - fetch_entry_t struct {pc4[31:0], instr[31:0]}.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with push, pop and flush ports, count output, flush having priority. The top level holds the FSM, PC, credit and squash logic.

Test Plan:
- Reset release, if_ready=1, ROM word i = 0x1000_0000+i:
  - Requests at 0x0040_0000, 0x0040_0004, … begin 1 cycle after reset release.
  - First if_valid 2 cycles after the first request, with if_instr=0x1000_0000, if_pc4=0x0040_0004.
  - Then 1 instruction per cycle.
- Hold if_ready=0 for 10 cycles:
  - Exactly 4 entries buffered and imem_req stays 0.
  - On release, all 4 entries drain in order with no loss or duplicate.
- Redirect to 0x0040_0020 with 3 entries queued and a read in flight:
  - if_valid=0 next cycle; no wrong-path instruction ever emitted.
  - Next request address is 0x0040_0020, 2 cycles later.
  - if_pc4=0x0040_0024 after 4 cycles.
- Redirect on two consecutive cycles (0x100, then 0x200): only 0x200-path instructions emerge.
- redirect_pc=0x0040_0013: fetch resumes at 0x0040_0010.
- fetch_pc=0xFFFF_FFFC: the next request address is 0x0000_0000.
- Assert reset with a full FIFO: outputs return to reset values next cycle.
- With FETCH_PERF_CNT_EN, 5 pops and 2 redirects: perf_fetched=5, perf_redirects=2.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch / prefetch stage.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc4, instr} entries with a registered head; flush beats push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     head_q, head_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0) && !flush;
        do_push  = push && !flush && ((count_q != CNT_W'(DEPTH)) || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            head_d   = '0;
        end else begin
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
            // The new head can be the entry being written this very cycle.
            if (count_d != '0) begin
                head_d = (do_push && (wr_ptr_q == rd_ptr_d)) ? push_data : mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = head_q;
    assign count = count_q;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch stage: PC generation, 1-cycle ROM reads, credit-limited prefetch FIFO, redirect squash.
// Optional FETCH_PERF_CNT_EN adds saturating pop/redirect counters.
//
// state   | meaning
// S_BOOT  | first cycle after reset, no request
// S_RUN   | normal fetch, request whenever FIFO credit allows
// S_FLUSH | bubble after a redirect, no request
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc4
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_redirects
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t     state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      pc4_cap_q, pc4_cap_d;
    logic             outstanding_q, outstanding_d;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     fifo_head, push_entry;
    logic             credit_ok, push, pop;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pc4_cap_d  = pc4_cap_q;
        imem_req   = 1'b0;
        // An in-flight read already owns one FIFO slot.
        credit_ok  = ((CNT_W+1)'(fifo_count) + (CNT_W+1)'(outstanding_q)) < (CNT_W+1)'(FIFO_DEPTH);
        unique case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN:   imem_req = credit_ok && !redirect_valid;
            S_FLUSH: state_d = S_RUN;
            default: state_d = S_BOOT;
        endcase
        if (imem_req) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            pc4_cap_d  = fetch_pc_q + 32'd4;
        end
        if (redirect_valid) begin
            state_d    = S_FLUSH;
            fetch_pc_d = word_align(redirect_pc);
        end
        outstanding_d = imem_req;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_BOOT;
            fetch_pc_q    <= RESET_PC;
            pc4_cap_q     <= '0;
            outstanding_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            pc4_cap_q     <= pc4_cap_d;
            outstanding_q <= outstanding_d;
        end
    end

    assign imem_addr  = fetch_pc_q;
    assign push       = outstanding_q && !redirect_valid;
    assign push_entry = '{pc4: pc4_cap_q, instr: imem_rdata};
    assign if_valid   = (fifo_count != '0);
    assign pop        = if_valid && if_ready;
    assign if_instr   = fifo_head.instr;
    assign if_pc4     = fifo_head.pc4;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (fifo_head),
        .count     (fifo_count)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_redirects_q, perf_redirects_d;

    always_comb begin
        perf_fetched_d   = perf_fetched_q;
        perf_redirects_d = perf_redirects_q;
        if (pop && (perf_fetched_q != '1))              perf_fetched_d   = perf_fetched_q + 32'd1;
        if (redirect_valid && (perf_redirects_q != '1)) perf_redirects_d = perf_redirects_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_fetched_q   <= '0;
            perf_redirects_q <= '0;
        end else begin
            perf_fetched_q   <= perf_fetched_d;
            perf_redirects_q <= perf_redirects_d;
        end
    end

    assign perf_fetched   = perf_fetched_q;
    assign perf_redirects = perf_redirects_q;
`endif

endmodule
